// File: rtl/player_action_ctrl.sv
// player_action_ctrl: debounced push-button front end producing one-cycle action
// strobes and a clamped bet amount for the hand FSM, with one action per turn.

package player_action_ctrl_pkg;
    localparam int unsigned MAX_STACK_W = 16;
    typedef logic [3:0] hand_state_t;
endpackage

module player_action_ctrl
    import player_action_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BET_STEP        = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_check_call,
    input  logic                   btn_bet_raise,
    input  logic                   btn_fold,
    input  logic                   btn_inc,
    input  logic                   btn_dec,
    input  logic                   btn_advance,
    input  logic                   act_enable,
    input  logic [MAX_STACK_W-1:0] min_bet_or_raise,
    input  logic [MAX_STACK_W-1:0] player_stack,
    input  hand_state_t            curr_state,
    input  logic                   current_player,
    output logic                   check_or_call,
    output logic                   bet_or_raise,
    output logic                   fold,
    output logic                   advance,
    output logic [MAX_STACK_W-1:0] bet_input,
    output logic                   busy
);

    localparam int unsigned NUM_BTN   = 6;
    localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned EXT_W     = MAX_STACK_W + 1;
    localparam int unsigned BTN_CHECK = 0;
    localparam int unsigned BTN_BET   = 1;
    localparam int unsigned BTN_FOLD  = 2;
    localparam int unsigned BTN_INC   = 3;
    localparam int unsigned BTN_DEC   = 4;
    localparam int unsigned BTN_ADV   = 5;

    typedef enum logic [1:0] {IDLE, READY, ISSUE, LOCK} state_t;

    logic [NUM_BTN-1:0] raw, sync1, sync2, deb, deb_d, press;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    state_t                 state_q, state_d;
    hand_state_t            cap_state_q, cap_state_d;
    logic                   cap_player_q, cap_player_d;
    logic                   check_or_call_d, bet_or_raise_d, fold_d, advance_d, busy_d;
    logic [MAX_STACK_W-1:0] bet_input_d;

    logic [MAX_STACK_W-1:0] bet_floor, bet_ceil, bet_clamped, bet_inc, bet_dec;
    logic [EXT_W-1:0]       inc_sum, dec_limit;
    logic                   any_action;

    assign raw = {btn_advance, btn_dec, btn_inc, btn_fold, btn_bet_raise, btn_check_call};

    // Per-button synchroniser, debounce counter and registered rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Bet limits; floor never exceeds ceiling, so a short stack can only go all-in
    assign bet_floor   = (min_bet_or_raise < player_stack) ? min_bet_or_raise : player_stack;
    assign bet_ceil    = player_stack;
    assign bet_clamped = (bet_input > bet_ceil)  ? bet_ceil  :
                         (bet_input < bet_floor) ? bet_floor : bet_input;
    assign inc_sum     = {1'b0, bet_clamped} + EXT_W'(BET_STEP);
    assign bet_inc     = (inc_sum > {1'b0, bet_ceil}) ? bet_ceil : inc_sum[MAX_STACK_W-1:0];
    assign dec_limit   = {1'b0, bet_floor} + EXT_W'(BET_STEP);
    assign bet_dec     = ({1'b0, bet_clamped} >= dec_limit) ?
                         (bet_clamped - MAX_STACK_W'(BET_STEP)) : bet_floor;

    assign any_action = press[BTN_FOLD] | press[BTN_CHECK] | press[BTN_BET] | press[BTN_ADV];

    // Next-state, next-strobe and bet update
    always_comb begin
        state_d         = state_q;
        bet_input_d     = bet_input;
        cap_state_d     = cap_state_q;
        cap_player_d    = cap_player_q;
        check_or_call_d = 1'b0;
        bet_or_raise_d  = 1'b0;
        fold_d          = 1'b0;
        advance_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (press[BTN_ADV]) begin
                    state_d   = ISSUE;
                    advance_d = 1'b1;
                end else if (act_enable) begin
                    state_d     = READY;
                    bet_input_d = bet_floor;
                end
            end
            READY: begin
                if (!act_enable) begin
                    state_d = IDLE;
                end else if (press[BTN_FOLD]) begin
                    state_d = ISSUE;
                    fold_d  = 1'b1;
                end else if (press[BTN_CHECK]) begin
                    state_d         = ISSUE;
                    check_or_call_d = 1'b1;
                end else if (press[BTN_BET] && (player_stack != '0)) begin
                    state_d        = ISSUE;
                    bet_or_raise_d = 1'b1;
                end else if (press[BTN_ADV]) begin
                    state_d   = ISSUE;
                    advance_d = 1'b1;
                end else if (!any_action && press[BTN_INC] && !press[BTN_DEC]) begin
                    bet_input_d = bet_inc;
                end else if (!any_action && press[BTN_DEC] && !press[BTN_INC]) begin
                    bet_input_d = bet_dec;
                end else begin
                    bet_input_d = bet_clamped;
                end
            end
            ISSUE: begin
                cap_state_d  = curr_state;
                cap_player_d = current_player;
                state_d      = LOCK;
            end
            LOCK: begin
                if ((curr_state != cap_state_q) || (current_player != cap_player_q) || !act_enable) begin
                    state_d     = act_enable ? READY : IDLE;
                    bet_input_d = bet_floor;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ISSUE) || (state_d == LOCK);
    end

    // State, capture and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cap_state_q   <= '0;
            cap_player_q  <= 1'b0;
            check_or_call <= 1'b0;
            bet_or_raise  <= 1'b0;
            fold          <= 1'b0;
            advance       <= 1'b0;
            bet_input     <= '0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_state_q   <= cap_state_d;
            cap_player_q  <= cap_player_d;
            check_or_call <= check_or_call_d;
            bet_or_raise  <= bet_or_raise_d;
            fold          <= fold_d;
            advance       <= advance_d;
            bet_input     <= bet_input_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl with DEBOUNCE_CYCLES=4, BET_STEP=10.

module tb_player_action_ctrl;
    import player_action_ctrl_pkg::*;

    localparam logic [5:0] M_CHECK = 6'b000001;
    localparam logic [5:0] M_BET   = 6'b000010;
    localparam logic [5:0] M_FOLD  = 6'b000100;
    localparam logic [5:0] M_INC   = 6'b001000;
    localparam logic [5:0] M_DEC   = 6'b010000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [5:0]             btn;
    logic                   act_enable;
    logic [MAX_STACK_W-1:0] min_bet_or_raise, player_stack;
    hand_state_t            curr_state;
    logic                   current_player;
    logic                   check_or_call, bet_or_raise, fold, advance, busy;
    logic [MAX_STACK_W-1:0] bet_input;

    int errors = 0;
    int checks = 0;

    int                     n_pulse  [4];
    int                     first_at [4];
    logic                   multi_hot;
    logic                   busy_log [64];
    logic [MAX_STACK_W-1:0] bet_log  [64];

    player_action_ctrl #(.DEBOUNCE_CYCLES(4), .BET_STEP(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_check_call   (btn[0]),
        .btn_bet_raise    (btn[1]),
        .btn_fold         (btn[2]),
        .btn_inc          (btn[3]),
        .btn_dec          (btn[4]),
        .btn_advance      (btn[5]),
        .act_enable       (act_enable),
        .min_bet_or_raise (min_bet_or_raise),
        .player_stack     (player_stack),
        .curr_state       (curr_state),
        .current_player   (current_player),
        .check_or_call    (check_or_call),
        .bet_or_raise     (bet_or_raise),
        .fold             (fold),
        .advance          (advance),
        .bet_input        (bet_input),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Drive mask high at a negedge, observe `window` negedges, release after `hold`
    task automatic pulse_watch(input logic [5:0] mask, input int hold, input int window);
        logic [3:0] strb;
        for (int s = 0; s < 4; s++) begin
            n_pulse[s]  = 0;
            first_at[s] = -1;
        end
        multi_hot = 1'b0;
        btn = btn | mask;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            strb = {advance, fold, bet_or_raise, check_or_call};
            if ($countones(strb) > 1) multi_hot = 1'b1;
            for (int s = 0; s < 4; s++) begin
                if (strb[s]) begin
                    n_pulse[s]++;
                    if (first_at[s] < 0) first_at[s] = k;
                end
            end
            busy_log[k] = busy;
            bet_log[k]  = bet_input;
            if (k == hold) btn = btn & ~mask;
        end
    endtask

    task automatic release_lock();
        curr_state = curr_state + 4'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({check_or_call, bet_or_raise, fold, advance, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000", {check_or_call, bet_or_raise, fold, advance, busy});
        end
        checks++;
        if (bet_input !== '0) begin
            errors++;
            $display("FAIL reset_bet: got %0d want 0", bet_input);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fold_basic();
        min_bet_or_raise = 16'd20;
        player_stack     = 16'd100;
        act_enable       = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bet_input !== 16'd20) begin
            errors++;
            $display("FAIL fold_ready_bet: got %0d want 20", bet_input);
        end
        pulse_watch(M_FOLD, 10, 14);
        checks++;
        if (n_pulse[2] !== 1) begin
            errors++;
            $display("FAIL fold_count: got %0d want 1", n_pulse[2]);
        end
        checks++;
        if (first_at[2] !== 9) begin
            errors++;
            $display("FAIL fold_latency: got cycle %0d want 9", first_at[2]);
        end
        checks++;
        if (n_pulse[0] + n_pulse[1] + n_pulse[3] !== 0) begin
            errors++;
            $display("FAIL fold_other_strobes: got %0d want 0", n_pulse[0] + n_pulse[1] + n_pulse[3]);
        end
        checks++;
        if (busy_log[8] !== 1'b0 || busy_log[9] !== 1'b1 || busy_log[14] !== 1'b1) begin
            errors++;
            $display("FAIL fold_busy: got %b%b%b want 011", busy_log[8], busy_log[9], busy_log[14]);
        end
        release_lock();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fold_unlock: busy got %b want 0", busy);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        int spur = 0;
        for (int k = 0; k < 20; k++) begin
            btn[0] = ((k % 4) < 2);
            @(negedge clk);
            if (check_or_call || bet_or_raise || fold || advance) spur++;
        end
        checks++;
        if (spur !== 0) begin
            errors++;
            $display("FAIL bounce_spurious: got %0d strobes want 0", spur);
        end
        pulse_watch(M_CHECK, 12, 14);
        checks++;
        if (n_pulse[0] !== 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d want 1", n_pulse[0]);
        end
        checks++;
        if (first_at[0] !== 9) begin
            errors++;
            $display("FAIL bounce_latency: got cycle %0d want 9", first_at[0]);
        end
        release_lock();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce_unlock: busy got %b want 0", busy);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_clamp();
        int unsigned inc_exp [4] = '{30, 40, 45, 45};
        int unsigned dec_exp [5] = '{35, 25, 20, 20, 20};
        player_stack = 16'd45;
        repeat (2) @(negedge clk);
        checks++;
        if (bet_input !== 16'd20) begin
            errors++;
            $display("FAIL clamp_start: got %0d want 20", bet_input);
        end
        for (int i = 0; i < 4; i++) begin
            pulse_watch(M_INC, 6, 16);
            if (i == 0) begin
                checks++;
                if (bet_log[8] !== 16'd20 || bet_log[9] !== 16'd30) begin
                    errors++;
                    $display("FAIL inc_latency: got %0d,%0d want 20,30", bet_log[8], bet_log[9]);
                end
            end
            checks++;
            if (bet_input !== 16'(inc_exp[i])) begin
                errors++;
                $display("FAIL inc_%0d: got %0d want %0d", i, bet_input, inc_exp[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            pulse_watch(M_DEC, 6, 16);
            checks++;
            if (bet_input !== 16'(dec_exp[i])) begin
                errors++;
                $display("FAIL dec_%0d: got %0d want %0d", i, bet_input, dec_exp[i]);
            end
        end
        pulse_watch(M_BET, 6, 16);
        checks++;
        if (n_pulse[1] !== 1 || first_at[1] !== 9) begin
            errors++;
            $display("FAIL bet_strobe: got count %0d at %0d want 1 at 9", n_pulse[1], first_at[1]);
        end
        checks++;
        if (bet_log[9] !== 16'd20) begin
            errors++;
            $display("FAIL bet_amount: got %0d want 20", bet_log[9]);
        end
        release_lock();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_short_stack();
        player_stack = 16'd15;
        repeat (2) @(negedge clk);
        checks++;
        if (bet_input !== 16'd15) begin
            errors++;
            $display("FAIL short_stack_bet: got %0d want 15", bet_input);
        end
        player_stack = 16'd0;
        pulse_watch(M_BET, 6, 16);
        checks++;
        if (n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3] !== 0) begin
            errors++;
            $display("FAIL zero_stack_strobe: got %0d strobes want 0", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3]);
        end
        checks++;
        if (busy_log[10] !== 1'b0 || busy_log[16] !== 1'b0) begin
            errors++;
            $display("FAIL zero_stack_busy: got %b%b want 00", busy_log[10], busy_log[16]);
        end
        player_stack = 16'd100;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        pulse_watch(M_FOLD | M_BET, 6, 16);
        checks++;
        if (n_pulse[2] !== 1 || first_at[2] !== 9) begin
            errors++;
            $display("FAIL simul_fold: got count %0d at %0d want 1 at 9", n_pulse[2], first_at[2]);
        end
        checks++;
        if (n_pulse[1] !== 0) begin
            errors++;
            $display("FAIL simul_bet: got %0d want 0", n_pulse[1]);
        end
        checks++;
        if (multi_hot !== 1'b0) begin
            errors++;
            $display("FAIL simul_onehot: got %b want 0", multi_hot);
        end
        pulse_watch(M_CHECK, 6, 16);
        checks++;
        if (n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3] !== 0) begin
            errors++;
            $display("FAIL lock_drop: got %0d strobes want 0", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3]);
        end
        checks++;
        if (busy_log[16] !== 1'b1) begin
            errors++;
            $display("FAIL lock_busy: got %b want 1", busy_log[16]);
        end
        current_player = ~current_player;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL player_unlock: busy got %b want 0", busy);
        end
        pulse_watch(M_CHECK, 6, 16);
        checks++;
        if (n_pulse[0] !== 1 || first_at[0] !== 9) begin
            errors++;
            $display("FAIL post_unlock_check: got count %0d at %0d want 1 at 9", n_pulse[0], first_at[0]);
        end
    endtask

    task automatic test_reset_mid();
        release_lock();
        repeat (4) @(negedge clk);
        pulse_watch(M_INC, 6, 16);
        pulse_watch(M_INC, 6, 16);
        pulse_watch(M_CHECK, 6, 16);
        checks++;
        if (bet_input !== 16'd40 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lock: got bet %0d busy %b want 40 1", bet_input, busy);
        end
        @(negedge clk);
        #2;
        btn[2] = 1'b1;
        reset  = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || {check_or_call, bet_or_raise, fold, advance} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl: got busy %b strobes %b want 0", busy, {check_or_call, bet_or_raise, fold, advance});
        end
        checks++;
        if (bet_input !== '0) begin
            errors++;
            $display("FAIL async_reset_bet: got %0d want 0", bet_input);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        pulse_watch(M_FOLD, 10, 14);
        checks++;
        if (n_pulse[2] !== 1) begin
            errors++;
            $display("FAIL held_reset_count: got %0d want 1", n_pulse[2]);
        end
        checks++;
        if (first_at[2] !== 9) begin
            errors++;
            $display("FAIL held_reset_latency: got cycle %0d want 9", first_at[2]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        btn              = '0;
        act_enable       = 1'b0;
        min_bet_or_raise = '0;
        player_stack     = '0;
        curr_state       = '0;
        current_player   = 1'b0;
        test_reset();
        test_fold_basic();
        test_bounce();
        test_clamp();
        test_short_stack();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
